pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush/forward controller for the 5-stage rv32i pipeline.
//  Drives the enable/clear pins of the F, D, E, M and W pipeline registers, including execute_stage.
//  Generates ALU operand forward selects; sequences multi-cycle data-memory accesses via a req/ack FSM with timeout.
//  Keeps a saturating stall-cycle counter for perf debug.
// PARAMETERS
//  MEM_TIMEOUT  16  max WAIT cycles before the access is declared failed (>=2)
//  CNT_W        32  width of stall-cycle counter
// PORTS
//  clk           in   1      clock, all state on rising edge
//  reset         in   1      synchronous, active-high reset
//  Rs1D, Rs2D    in   5      source regs in decode
//  Rs1E, Rs2E    in   5      source regs in execute
//  RdE           in   5      dest reg in execute
//  resultsrcE    in   1      1 = instruction in E is a load
//  pcsrcE        in   1      1 = taken branch/jump resolved in E
//  RdM           in   5      dest reg in memory stage
//  regwriteM     in   1      M-stage instruction writes RF
//  resultsrcM    in   1      M-stage load
//  memwriteM     in   1      M-stage store
//  RdW           in   5      dest reg in writeback
//  regwriteW     in   1      W-stage instruction writes RF
//  dmem_ack      in   1      data memory completes access this cycle
//  forwardAE     out  2      operand A select: 00 RF, 01 W result, 10 M aluresult
//  forwardBE     out  2      operand B select, same encoding
//  stallF/D/E/M  out  1 each hold PC / F-D / D-E / E-M registers
//  flushD, flushE out 1 each clear F-D / D-E registers to bubble
//  flushW        out  1      clear M-W register (bubble into writeback)
//  dmem_req      out  1      data memory request
//  mem_err       out  1      sticky: access timed out; pipeline halted
//  stall_cnt     out  CNT_W  cycles with stallF=1, saturates at all-ones
// BEHAVIOUR
//  Forwarding (comb): fwdA=10 if regwriteM && RdM!=0 && RdM==Rs1E; else 01 if regwriteW && RdW!=0 && RdW==Rs1E; else 00. M wins over W. B identical on Rs2E.
//  lwstall (comb) = resultsrcE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
//  memop = resultsrcM | memwriteM. FSM states IDLE, WAIT, ERR; wait counter TO_W=$clog2(MEM_TIMEOUT+1).
//   IDLE: dmem_req=memop. memop && dmem_ack -> stay IDLE, zero-wait, no stall. memop && !ack -> WAIT, cnt<=1.
//   WAIT: dmem_req=1. ack -> IDLE, memstall=0 that cycle. !ack && cnt==MEM_TIMEOUT-1 -> ERR. else cnt++.
//   ERR: dmem_req=0, mem_err=1, memstall=1 forever; leaves only on reset.
//  memstall = (IDLE && memop && !ack) || (WAIT && !ack) || ERR.
//  stallF=stallD = lwstall | memstall.  stallE=stallM=flushW = memstall.
//  flushD = pcsrcE && !memstall.  flushE = (lwstall | pcsrcE) && !memstall.
//  lwstall + pcsrcE same cycle: flushE=1, flushD=1, stallF/D=1 (branch redirect wins on next unstalled cycle).
//  dmem_ack in IDLE with memop=0: ignored. ack in ERR: ignored.
//  stall_cnt: +1 each cycle stallF=1, holds at 2^CNT_W-1.
//  Reset: state=IDLE, cnt=0, mem_err=0, stall_cnt=0; with idle inputs all stall/flush/req outputs 0, fwd=00.
//  Reset asserted in WAIT/ERR: IDLE next edge; dmem_req follows IDLE rule after the edge.
// STRUCTURE
//  rv32i_pkg adds: typedef enum logic [1:0] fwd_sel_e {FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10};
//   typedef enum logic [1:0] memctl_state_e {MC_IDLE, MC_WAIT, MC_ERR}.
//  Sub-module forward_unit (comb, per operand: RsE, RdM, regwriteM, RdW, regwriteW -> fwd_sel_e), instantiated twice.
//  FSM, wait counter, stall counter and stall/flush logic in this module.
// TESTING
//  Rs1E=5, RdM=5 regwriteM=1, RdW=5 regwriteW=1 -> forwardAE=10; RdM=0 -> 01; RdW=0 too -> 00.
//  resultsrcE=1 RdE=7 Rs2D=7 -> stallF=stallD=flushE=1, stallE=0; RdE=0 -> all 0.
//  memop=1 dmem_ack=1 same cycle -> dmem_req=1, no stall, state stays IDLE.
//  memop=1, ack after 3 cycles -> stallF..M=flushW=1 for exactly 3 cycles, 0 on ack cycle; stall_cnt=3.
//  MEM_TIMEOUT=4, memop=1 no ack -> ERR after 4 stalled cycles, mem_err=1, dmem_req=0, stalls stay 1; reset clears all.
//  pcsrcE=1 while memstall -> flushD=flushE=0 until ack; flush on ack cycle.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the rv32i hazard controller: forward selects and memory-control FSM states.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        MC_IDLE = 2'b00,
        MC_WAIT = 2'b01,
        MC_ERR  = 2'b10
    } memctl_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller: stage register ids/controls in, stall/flush/forward out.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       Rs1D, Rs2D;
    logic [4:0]       Rs1E, Rs2E, RdE;
    logic             resultsrcE;
    logic             pcsrcE;
    logic [4:0]       RdM;
    logic             regwriteM;
    logic             resultsrcM;
    logic             memwriteM;
    logic [4:0]       RdW;
    logic             regwriteW;
    logic             dmem_ack;
    logic [1:0]       forwardAE, forwardBE;
    logic             stallF, stallD, stallE, stallM;
    logic             flushD, flushE, flushW;
    logic             dmem_req;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, resultsrcE, pcsrcE,
               RdM, regwriteM, resultsrcM, memwriteM, RdW, regwriteW, dmem_ack,
        input  forwardAE, forwardBE, stallF, stallD, stallE, stallM,
               flushD, flushE, flushW, dmem_req, mem_err, stall_cnt
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, resultsrcE, pcsrcE,
               RdM, regwriteM, resultsrcM, memwriteM, RdW, regwriteW, dmem_ack,
        output forwardAE, forwardBE, stallF, stallD, stallE, stallM,
               flushD, flushE, flushW, dmem_req, mem_err, stall_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_forward_unit.sv
// Per-operand ALU forward select; the newer M-stage result takes priority over W.
module forward_unit
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] rs_e,
    input  logic [REG_W-1:0] rd_m,
    input  logic             regwrite_m,
    input  logic [REG_W-1:0] rd_w,
    input  logic             regwrite_w,
    output fwd_sel_e         sel
);
    always_comb begin
        sel = FWD_RF;
        if (regwrite_m && (rd_m != '0) && (rd_m == rs_e))
            sel = FWD_M;
        else if (regwrite_w && (rd_w != '0) && (rd_w == rs_e))
            sel = FWD_W;
    end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage rv32i pipeline with a timed data-memory handshake.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int unsigned TO_W = $clog2(MEM_TIMEOUT + 1);

    memctl_state_e    state_q, state_d;
    logic [TO_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             memop, memstall, lwstall, stall_fd;
    fwd_sel_e         fwd_a, fwd_b;

    forward_unit u_fwd_a (
        .rs_e      (bus.Rs1E),
        .rd_m      (bus.RdM),
        .regwrite_m(bus.regwriteM),
        .rd_w      (bus.RdW),
        .regwrite_w(bus.regwriteW),
        .sel       (fwd_a)
    );

    forward_unit u_fwd_b (
        .rs_e      (bus.Rs2E),
        .rd_m      (bus.RdM),
        .regwrite_m(bus.regwriteM),
        .rd_w      (bus.RdW),
        .regwrite_w(bus.regwriteW),
        .sel       (fwd_b)
    );

    assign memop   = bus.resultsrcM | bus.memwriteM;
    assign lwstall = bus.resultsrcE && (bus.RdE != '0) &&
                     ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MC_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            MC_IDLE: begin
                if (memop && !bus.dmem_ack) begin
                    state_d = MC_WAIT;
                    wait_d  = TO_W'(1);
                end
            end
            MC_WAIT: begin
                if (bus.dmem_ack)
                    state_d = MC_IDLE;
                else if (wait_q == TO_W'(MEM_TIMEOUT - 1))
                    state_d = MC_ERR;
                else
                    wait_d = wait_q + TO_W'(1);
            end
            MC_ERR:  state_d = MC_ERR;
            default: state_d = MC_IDLE;
        endcase
    end

    // ERR keeps the whole pipeline frozen; only reset leaves it.
    always_comb begin
        bus.dmem_req = 1'b0;
        bus.mem_err  = 1'b0;
        memstall     = 1'b0;
        unique case (state_q)
            MC_IDLE: begin
                bus.dmem_req = memop;
                memstall     = memop && !bus.dmem_ack;
            end
            MC_WAIT: begin
                bus.dmem_req = 1'b1;
                memstall     = !bus.dmem_ack;
            end
            MC_ERR: begin
                bus.mem_err = 1'b1;
                memstall    = 1'b1;
            end
            default: ;
        endcase
    end

    assign stall_fd   = lwstall | memstall;
    assign bus.stallF = stall_fd;
    assign bus.stallD = stall_fd;
    assign bus.stallE = memstall;
    assign bus.stallM = memstall;
    assign bus.flushW = memstall;
    assign bus.flushD = bus.pcsrcE && !memstall;
    assign bus.flushE = (lwstall | bus.pcsrcE) && !memstall;

    assign bus.forwardAE = fwd_a;
    assign bus.forwardBE = fwd_b;

    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt_q <= '0;
        else if (stall_fd && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end

    assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a short memory timeout and narrow stall counter.
module tb_pipeline_hazard_ctrl;
    localparam int unsigned TB_TIMEOUT = 4;
    localparam int unsigned TB_CNT_W   = 4;

    logic clk = 1'b0;
    logic reset;
    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    pipeline_hazard_ctrl_if #(.CNT_W(TB_CNT_W)) bus ();

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT(TB_TIMEOUT),
        .CNT_W      (TB_CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic idle_inputs();
        bus.Rs1D = '0; bus.Rs2D = '0;
        bus.Rs1E = '0; bus.Rs2E = '0; bus.RdE = '0;
        bus.resultsrcE = 1'b0; bus.pcsrcE = 1'b0;
        bus.RdM = '0; bus.regwriteM = 1'b0; bus.resultsrcM = 1'b0; bus.memwriteM = 1'b0;
        bus.RdW = '0; bus.regwriteW = 1'b0;
        bus.dmem_ack = 1'b0;
    endtask

    // Packs {stallF,stallD,stallE,stallM,flushW} for compact stall checks.
    function automatic logic [4:0] stalls();
        return {bus.stallF, bus.stallD, bus.stallE, bus.stallM, bus.flushW};
    endfunction

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_stalls", 32'(stalls()), 32'h00);
        check("rst_flush", 32'({bus.flushD, bus.flushE}), 32'h0);
        check("rst_req", 32'(bus.dmem_req), 32'h0);
        check("rst_err", 32'(bus.mem_err), 32'h0);
        check("rst_fwd", 32'({bus.forwardAE, bus.forwardBE}), 32'h0);
        check("rst_cnt", 32'(bus.stall_cnt), 32'h0);

        // Forwarding priority.
        @(negedge clk);
        bus.Rs1E = 5'd5; bus.RdM = 5'd5; bus.regwriteM = 1'b1; bus.RdW = 5'd5; bus.regwriteW = 1'b1;
        bus.Rs2E = 5'd9;
        #1;
        check("fwdA_m", 32'(bus.forwardAE), 32'h2);
        check("fwdB_none", 32'(bus.forwardBE), 32'h0);
        bus.RdM = 5'd0;
        #1;
        check("fwdA_w", 32'(bus.forwardAE), 32'h1);
        bus.RdW = 5'd0;
        #1;
        check("fwdA_rf", 32'(bus.forwardAE), 32'h0);
        @(negedge clk);
        bus.RdM = 5'd9; bus.regwriteM = 1'b0; bus.RdW = 5'd9; bus.Rs1E = 5'd9;
        #1;
        check("fwdB_w_nowrM", 32'(bus.forwardBE), 32'h1);
        check("fwdA_w_nowrM", 32'(bus.forwardAE), 32'h1);
        bus.regwriteM = 1'b1; bus.Rs1E = 5'd3; bus.RdW = 5'd3;
        #1;
        check("fwdB_m", 32'(bus.forwardBE), 32'h2);
        check("fwdA_w2", 32'(bus.forwardAE), 32'h1);
        idle_inputs();

        // Load-use stall, kept off the clock edge so stall_cnt is untouched.
        @(negedge clk);
        bus.resultsrcE = 1'b1; bus.RdE = 5'd7; bus.Rs2D = 5'd7;
        #1;
        check("lw_stalls", 32'(stalls()), 32'h18);
        check("lw_flush", 32'({bus.flushD, bus.flushE}), 32'h1);
        bus.RdE = 5'd0;
        #1;
        check("lw_rd0", 32'({stalls(), bus.flushD, bus.flushE}), 32'h0);
        bus.RdE = 5'd7; bus.Rs2D = 5'd0; bus.Rs1D = 5'd7; bus.pcsrcE = 1'b1;
        #1;
        check("lw_br_stalls", 32'(stalls()), 32'h18);
        check("lw_br_flush", 32'({bus.flushD, bus.flushE}), 32'h3);
        bus.resultsrcE = 1'b0;
        #1;
        check("br_only", 32'({stalls(), bus.flushD, bus.flushE}), 32'h3);
        idle_inputs();

        // Zero-wait access and ack with no memop.
        @(negedge clk);
        bus.resultsrcM = 1'b1; bus.dmem_ack = 1'b1;
        #1;
        check("zw_req", 32'(bus.dmem_req), 32'h1);
        check("zw_stalls", 32'(stalls()), 32'h00);
        @(negedge clk);
        bus.resultsrcM = 1'b0;
        #1;
        check("ack_no_memop", 32'({bus.dmem_req, stalls()}), 32'h00);
        check("zw_cnt", 32'(bus.stall_cnt), 32'h0);
        idle_inputs();

        // Ack arrives on the fourth cycle: three stalled cycles; branch flush held off until then.
        @(negedge clk);
        bus.memwriteM = 1'b1;
        #1;
        check("mw0_stalls", 32'({bus.dmem_req, stalls()}), 32'h3F);
        @(negedge clk);
        bus.pcsrcE = 1'b1;
        #1;
        check("mw1_stalls", 32'({bus.dmem_req, stalls()}), 32'h3F);
        check("mw1_flush", 32'({bus.flushD, bus.flushE}), 32'h0);
        @(negedge clk);
        #1;
        check("mw2_stalls", 32'({bus.dmem_req, stalls()}), 32'h3F);
        check("mw2_flush", 32'({bus.flushD, bus.flushE}), 32'h0);
        @(negedge clk);
        bus.dmem_ack = 1'b1;
        #1;
        check("mw3_ack", 32'({bus.dmem_req, stalls()}), 32'h20);
        check("mw3_flush", 32'({bus.flushD, bus.flushE}), 32'h3);
        @(negedge clk);
        idle_inputs();
        #1;
        check("mw_idle_req", 32'(bus.dmem_req), 32'h0);
        check("mw_cnt", 32'(bus.stall_cnt), 32'h3);

        // Timeout: four stalled cycles then ERR.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.resultsrcM = 1'b1;
            #1;
            check($sformatf("to%0d_stalls", i), 32'({bus.dmem_req, bus.mem_err, stalls()}), 32'h5F);
        end
        @(negedge clk);
        #1;
        check("err_flags", 32'({bus.dmem_req, bus.mem_err, stalls()}), 32'h3F);
        check("err_cnt", 32'(bus.stall_cnt), 32'h7);
        @(negedge clk);
        bus.resultsrcM = 1'b0; bus.dmem_ack = 1'b1; bus.pcsrcE = 1'b1;
        #1;
        check("err_ack_ign", 32'({bus.dmem_req, bus.mem_err, stalls()}), 32'h3F);
        check("err_noflush", 32'({bus.flushD, bus.flushE}), 32'h0);
        repeat (11) @(negedge clk);
        #1;
        check("cnt_sat", 32'(bus.stall_cnt), 32'hF);
        check("err_sticky", 32'(bus.mem_err), 32'h1);

        // Reset clears ERR.
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst2_flags", 32'({bus.dmem_req, bus.mem_err, stalls()}), 32'h00);
        check("rst2_cnt", 32'(bus.stall_cnt), 32'h0);

        // Reset taken while in WAIT returns to IDLE.
        bus.memwriteM = 1'b1;
        #1;
        check("pre_wait_req", 32'({bus.dmem_req, stalls()}), 32'h3F);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.memwriteM = 1'b0;
        #1;
        check("rst_wait_idle", 32'({bus.dmem_req, bus.mem_err, stalls()}), 32'h00);
        check("rst_wait_cnt", 32'(bus.stall_cnt), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
